// File: rtl/exec_if.sv
// Issue/writeback bundle between the decode stage, exec_unit and the register file.
interface exec_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [2:0]       rd;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wb_wen;
  logic [2:0]       wb_rd;
  logic [WIDTH-1:0] wb_din;
  logic             flag_z;
  logic             flag_c;

  modport master (output in_valid, op, rd, a, b,
                  input  in_ready, wb_wen, wb_rd, wb_din, flag_z, flag_c);
  modport slave  (input  in_valid, op, rd, a, b,
                  output in_ready, wb_wen, wb_rd, wb_din, flag_z, flag_c);
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops in IDLE, iterative shift-add MUL/MULH in MULT,
// registered register-file writeback and Z/C flags for the branch unit.
module exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  exec_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_MUL = 4'd7,
    OP_MULH = 4'd8, OP_MOV = 4'd9, OP_CMP = 4'd10
  } op_e;

  typedef enum logic {IDLE, MULT} state_e;

  state_e             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand, acc, prod;
  logic [WIDTH-1:0]   mplier;
  logic               is_mulh;
  logic [2:0]         mrd;

  logic             wen_q, z_q, c_q;
  logic [2:0]       rd_q;
  logic [WIDTH-1:0] din_q;

  logic             accept;
  logic [WIDTH:0]   sum, diff, shl_t, shr_t;
  logic [2:0]       amt;
  logic [WIDTH-1:0] res;
  logic             cout, wr, fupd;

  assign bus.in_ready = (state == IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.wb_wen   = wen_q;
  assign bus.wb_rd    = rd_q;
  assign bus.wb_din   = din_q;
  assign bus.flag_z   = z_q;
  assign bus.flag_c   = c_q;

  assign amt   = bus.b[2:0];
  assign sum   = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff  = {1'b0, bus.a} - {1'b0, bus.b};
  // The extra bit catches the last bit shifted out; a zero shift leaves it 0.
  assign shl_t = {1'b0, bus.a} << amt;
  assign shr_t = {bus.a, 1'b0} >> amt;

  always_comb begin
    res  = '0;
    cout = 1'b0;
    wr   = 1'b0;
    fupd = 1'b0;
    case (bus.op)
      OP_ADD: begin res = sum[WIDTH-1:0];   cout = sum[WIDTH];  wr = 1'b1; fupd = 1'b1; end
      OP_SUB: begin res = diff[WIDTH-1:0];  cout = diff[WIDTH]; wr = 1'b1; fupd = 1'b1; end
      OP_AND: begin res = bus.a & bus.b;    wr = 1'b1; fupd = 1'b1; end
      OP_OR:  begin res = bus.a | bus.b;    wr = 1'b1; fupd = 1'b1; end
      OP_XOR: begin res = bus.a ^ bus.b;    wr = 1'b1; fupd = 1'b1; end
      OP_SHL: begin res = shl_t[WIDTH-1:0]; cout = shl_t[WIDTH]; wr = 1'b1; fupd = 1'b1; end
      OP_SHR: begin res = shr_t[WIDTH:1];   cout = shr_t[0];     wr = 1'b1; fupd = 1'b1; end
      OP_MOV: begin res = bus.b;            wr = 1'b1; end
      OP_CMP: begin res = diff[WIDTH-1:0];  cout = diff[WIDTH]; fupd = 1'b1; end
      default: ;
    endcase
  end

  // Accumulator value after the current step; on the last step this is the full product.
  assign prod = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      is_mulh <= 1'b0;
      mrd     <= '0;
      wen_q   <= 1'b0;
      rd_q    <= '0;
      din_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (bus.op == OP_MUL || bus.op == OP_MULH) begin
            mcand   <= {{WIDTH{1'b0}}, bus.a};
            mplier  <= bus.b;
            acc     <= '0;
            cnt     <= CW'(WIDTH - 1);
            is_mulh <= (bus.op == OP_MULH);
            mrd     <= bus.rd;
            state   <= MULT;
          end else begin
            if (wr) begin
              wen_q <= 1'b1;
              rd_q  <= bus.rd;
              din_q <= res;
            end
            if (fupd) begin
              z_q <= (res == '0);
              c_q <= cout;
            end
          end
        end
        MULT: begin
          acc    <= prod;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            wen_q <= 1'b1;
            rd_q  <= mrd;
            if (is_mulh) begin
              din_q <= prod[2*WIDTH-1:WIDTH];
              z_q   <= (prod[2*WIDTH-1:WIDTH] == '0);
              c_q   <= 1'b0;
            end else begin
              din_q <= prod[WIDTH-1:0];
              z_q   <= (prod[WIDTH-1:0] == '0);
              c_q   <= (prod[2*WIDTH-1:WIDTH] != '0);
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: transaction-level model checked every cycle, plus directed literal checks.
module tb_exec_unit;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  exec_if #(.WIDTH(W)) bus();
  exec_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Model: results computed from the op table with integer arithmetic; a MUL/MULH
  // occupies the unit for W edges after acceptance, then writes back.
  int         busy = 0;
  logic       e_wen = 1'b0, e_z = 1'b0, e_c = 1'b0;
  logic [2:0] e_rd = '0;
  logic [7:0] e_din = '0;
  logic [2:0] p_rd = '0;
  logic [7:0] p_din = '0;
  logic       p_z = 1'b0, p_c = 1'b0;

  always @(posedge clk) begin
    int ai, bi, sh, t, r;
    logic c, wr, fl;
    e_wen = 1'b0;
    if (rst) begin
      busy = 0; e_z = 1'b0; e_c = 1'b0; e_rd = '0; e_din = '0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        e_wen = 1'b1; e_rd = p_rd; e_din = p_din; e_z = p_z; e_c = p_c;
      end
    end else if (bus.in_valid) begin
      ai = int'(bus.a); bi = int'(bus.b); sh = bi % 8;
      r = 0; c = 1'b0; wr = 1'b1; fl = 1'b1;
      case (int'(bus.op))
        0: begin t = ai + bi; r = t % 256; c = (t >= 256); end
        1, 10: begin r = (ai - bi + 256) % 256; c = (ai < bi); wr = (bus.op == 4'd1); end
        2: r = ai & bi;
        3: r = ai | bi;
        4: r = ai ^ bi;
        5: begin r = (ai << sh) % 256; c = (sh != 0) && (((ai >> (8 - sh)) & 1) == 1); end
        6: begin r = ai >> sh; c = (sh != 0) && (((ai >> (sh - 1)) & 1) == 1); end
        7, 8: begin
          t = ai * bi;
          if (bus.op == 4'd7) begin r = t % 256; c = (t / 256) != 0; end
          else begin r = t / 256; c = 1'b0; end
          busy = W; p_rd = bus.rd; p_din = 8'(r); p_z = (r == 0); p_c = c;
          wr = 1'b0; fl = 1'b0;
        end
        9: begin r = bi; fl = 1'b0; end
        default: begin wr = 1'b0; fl = 1'b0; end
      endcase
      if (wr) begin e_wen = 1'b1; e_rd = bus.rd; e_din = 8'(r); end
      if (fl) begin e_z = (r == 0); e_c = c; end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (bus.in_ready !== (!rst && busy == 0)) begin
      errors++; $display("FAIL mdl_ready t=%0t got %b want %b", $time, bus.in_ready, !rst && busy == 0);
    end
    checks++;
    if (bus.wb_wen !== e_wen || bus.flag_z !== e_z || bus.flag_c !== e_c) begin
      errors++;
      $display("FAIL mdl_wen_flags t=%0t got wen=%b z=%b c=%b want wen=%b z=%b c=%b",
               $time, bus.wb_wen, bus.flag_z, bus.flag_c, e_wen, e_z, e_c);
    end
    if (e_wen) begin
      checks++;
      if (bus.wb_rd !== e_rd || bus.wb_din !== e_din) begin
        errors++;
        $display("FAIL mdl_wb t=%0t got rd=%0d din=%h want rd=%0d din=%h",
                 $time, bus.wb_rd, bus.wb_din, e_rd, e_din);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++; $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Present an op and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [3:0] o, input logic [2:0] r,
                      input logic [7:0] av, input logic [7:0] bv);
    int n = 0;
    bus.in_valid = 1'b1; bus.op = o; bus.rd = r; bus.a = av; bus.b = bv;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin n++; @(negedge clk); end
    if (!bus.in_ready) begin errors++; $display("FAIL send_timeout op=%0d", o); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Count negedges until a writeback appears; leaves time at that negedge.
  task automatic wait_wb(output int n);
    n = 0;
    @(negedge clk);
    while (!bus.wb_wen && n < 40) begin n++; @(negedge clk); end
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.op = '0; bus.rd = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {7'b0, bus.in_ready}, 8'h00);
    chk("rst_wen",   {7'b0, bus.wb_wen}, 8'h00);
    chk("rst_din",   bus.wb_din, 8'h00);
    chk("rst_flags", {6'b0, bus.flag_z, bus.flag_c}, 8'h00);
    rst = 1'b0;
    #1 chk("ready_after_rst", {7'b0, bus.in_ready}, 8'h01);

    send(4'd0, 3'd3, 8'hF0, 8'h20);
    chk("add_wen", {7'b0, bus.wb_wen}, 8'h01);
    chk("add_rd",  {5'b0, bus.wb_rd}, 8'h03);
    chk("add_din", bus.wb_din, 8'h10);
    chk("add_zc",  {6'b0, bus.flag_z, bus.flag_c}, 8'h01);
    @(posedge clk); #1;
    chk("add_wen_drop", {7'b0, bus.wb_wen}, 8'h00);

    send(4'd1, 3'd1, 8'h05, 8'h05);
    chk("sub_din", bus.wb_din, 8'h00);
    chk("sub_zc",  {6'b0, bus.flag_z, bus.flag_c}, 8'h02);
    chk("b2b_ready1", {7'b0, bus.in_ready}, 8'h01);
    send(4'd10, 3'd0, 8'h03, 8'h07);
    chk("cmp_wen", {7'b0, bus.wb_wen}, 8'h00);
    chk("cmp_zc",  {6'b0, bus.flag_z, bus.flag_c}, 8'h01);
    send(4'd5, 3'd2, 8'h81, 8'h01);
    chk("shl_din", bus.wb_din, 8'h02);
    chk("shl_zc",  {6'b0, bus.flag_z, bus.flag_c}, 8'h01);
    send(4'd6, 3'd2, 8'h81, 8'h01);
    chk("shr_din", bus.wb_din, 8'h40);
    chk("shr_c",   {7'b0, bus.flag_c}, 8'h01);
    send(4'd5, 3'd2, 8'h81, 8'h00);
    chk("shl0_c",  {7'b0, bus.flag_c}, 8'h00);
    send(4'd4, 3'd6, 8'hA5, 8'hA5);
    chk("xor_zero", {6'b0, bus.flag_z, bus.flag_c}, 8'h02);
    send(4'd3, 3'd0, 8'h0C, 8'h30);
    chk("or_r0", bus.wb_din, 8'h3C);
    send(4'd2, 3'd7, 8'h0C, 8'h3A);
    chk("and_din", bus.wb_din, 8'h08);

    // MUL with a queued MOV held on the bus behind it
    send(4'd7, 3'd4, 8'hFF, 8'hFF);
    bus.in_valid = 1'b1; bus.op = 4'd9; bus.rd = 3'd5; bus.a = 8'h00; bus.b = 8'h5A;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin n++; @(negedge clk); end
    chk("mul_stall_cycles", 8'(n), 8'd8);
    chk("mul_wen", {7'b0, bus.wb_wen}, 8'h01);
    chk("mul_din", bus.wb_din, 8'h01);
    chk("mul_zc",  {6'b0, bus.flag_z, bus.flag_c}, 8'h01);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("mov_din", bus.wb_din, 8'h5A);
    chk("mov_rd",  {5'b0, bus.wb_rd}, 8'h05);

    send(4'd8, 3'd6, 8'hFF, 8'hFF);
    wait_wb(n);
    chk("mulh_lat", 8'(n), 8'd8);
    chk("mulh_din", bus.wb_din, 8'hFE);
    chk("mulh_zc",  {6'b0, bus.flag_z, bus.flag_c}, 8'h00);
    @(posedge clk); #1;
    send(4'd7, 3'd7, 8'h00, 8'h37);
    wait_wb(n);
    chk("mul0_din", bus.wb_din, 8'h00);
    chk("mul0_zc",  {6'b0, bus.flag_z, bus.flag_c}, 8'h02);
    @(posedge clk); #1;

    // Reset in the middle of a multiply
    send(4'd7, 3'd1, 8'h12, 8'h34);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("midrst_ready", {7'b0, bus.in_ready}, 8'h00);
    @(posedge clk); #1;
    chk("midrst_wen",   {7'b0, bus.wb_wen}, 8'h00);
    chk("midrst_flags", {6'b0, bus.flag_z, bus.flag_c}, 8'h00);
    chk("midrst_din",   bus.wb_din, 8'h00);
    rst = 1'b0;
    #1 chk("midrst_ready_after", {7'b0, bus.in_ready}, 8'h01);
    repeat (10) begin
      @(negedge clk);
      chk("midrst_no_wb", {7'b0, bus.wb_wen}, 8'h00);
    end
    @(posedge clk); #1;
    send(4'd0, 3'd2, 8'h01, 8'h01);
    chk("post_rst_add", bus.wb_din, 8'h02);

    // Flags from CMP persist across NOP and MOV
    send(4'd10, 3'd0, 8'h01, 8'h02);
    send(4'd15, 3'd3, 8'h00, 8'h00);
    chk("nop_wen", {7'b0, bus.wb_wen}, 8'h00);
    chk("nop_flags", {6'b0, bus.flag_z, bus.flag_c}, 8'h01);
    send(4'd9, 3'd3, 8'hFF, 8'h00);
    chk("mov0_din", bus.wb_din, 8'h00);
    chk("mov0_flags", {6'b0, bus.flag_z, bus.flag_c}, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
